// File: rtl/demux_1xn_reg.sv
// demux_1xn_reg: registered 1-to-N stream demultiplexer.
// Each output channel has one holding register and a valid flag. A stalled
// consumer only back-pressures words that are aimed at its own channel. A
// word whose select is out of range is accepted and discarded, and the
// discard is counted in a saturating 8-bit counter.
module demux_1xn_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [7:0]           drop_cnt
);

  // One-hot decode of in_sel. All zeros means the select is out of range.
  // This works for any N and never needs an "in_sel < N" compare, which
  // would always be true when N is a power of two.
  logic [N-1:0]     w_match;
  // Channel k can take a word: it is empty, or it is draining this cycle.
  logic [N-1:0]     w_room;
  logic [N-1:0]     w_load;
  logic             w_sel_ok;
  logic             w_accept;
  logic             w_drop;

  logic             r_valid [N];
  logic [WIDTH-1:0] r_data  [N];
  logic [7:0]       r_drop_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign w_match[gi] = (in_sel == SEL_W'(gi));
      assign w_room[gi]  = ~r_valid[gi] | out_ready[gi];

      // Holding register for channel gi. A load takes priority over a
      // drain, so a word that arrives while the old one drains replaces it
      // and the valid flag stays high. The data is not cleared on a drain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
        end else if (w_load[gi]) begin
          r_valid[gi] <= 1'b1;
          r_data[gi]  <= in_data;
        end else if (out_ready[gi]) begin
          r_valid[gi] <= 1'b0;
        end
      end

      assign out_valid[gi]                 = r_valid[gi];
      assign out_data[gi*WIDTH +: WIDTH]   = r_data[gi];
    end
  endgenerate

  assign w_sel_ok = |w_match;

  // Out-of-range words are always sunk. In-range words wait only for the
  // selected channel.
  assign in_ready = w_sel_ok ? |(w_match & w_room) : 1'b1;
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_match & {N{w_accept}};
  assign w_drop   = w_accept & ~w_sel_ok;

  // Count discarded out-of-range words. The counter holds at 255 instead of
  // wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule
